// File: rtl/jtag_mem_arbiter.sv
// Shares the single-port SRAM between the CPU data port and the JTAG debug loader.
// JTAG enable/request arrive from the tck domain and are synchronised here.
module jtag_mem_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned MEM_DATA_WIDTH = 32,
  parameter int unsigned RST_CYCLES     = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      jtag_en_async,
  input  logic                      jtag_req_async,
  input  logic                      jtag_we,
  input  logic [MEM_ADDR_WIDTH-1:0] jtag_addr,
  input  logic [MEM_DATA_WIDTH-1:0] jtag_wdata,
  output logic [MEM_DATA_WIDTH-1:0] jtag_rdata,
  output logic                      jtag_ack,
  output logic                      jtag_overrun,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [MEM_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [MEM_DATA_WIDTH-1:0] cpu_wdata,
  output logic [MEM_DATA_WIDTH-1:0] cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_halt,
  output logic                      cpu_rst_req,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StCpu, StDrain, StJtagIdle, StJtagAccess, StJtagRead, StRelease
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] en_sync_q, req_sync_q;
  logic                   req_s_q;
  logic                   en_s, req_s, req_evt;

  logic                      cpu_pend_q, cpu_pend_d;
  logic                      cpu_pend_we_q, cpu_pend_we_d;
  logic                      cpu_halt_q, cpu_halt_d;
  logic                      cpu_rst_req_q, cpu_rst_req_d;
  logic [MEM_DATA_WIDTH-1:0] cpu_rdata_q;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic                      jtag_we_q;
  logic [MEM_ADDR_WIDTH-1:0] jtag_addr_q;
  logic [MEM_DATA_WIDTH-1:0] jtag_wdata_q;
  logic [MEM_DATA_WIDTH-1:0] jtag_rdata_q;
  logic                      jtag_ack_q, jtag_ack_d;
  logic                      overrun_q, overrun_d;

  logic cpu_issue, jtag_issue, jtag_capture, jtag_rd_done, cpu_rd_done;

  assign en_s    = en_sync_q[SYNC_STAGES-1];
  assign req_s   = req_sync_q[SYNC_STAGES-1];
  assign req_evt = req_s & ~req_s_q;

  always_comb begin
    state_d       = state_q;
    cpu_pend_d    = 1'b0;  // a pending CPU access always completes the cycle after issue
    cpu_pend_we_d = cpu_pend_we_q;
    cpu_halt_d    = cpu_halt_q;
    cpu_rst_req_d = cpu_rst_req_q;
    cnt_d         = cnt_q;
    jtag_ack_d    = 1'b0;
    jtag_capture  = 1'b0;
    jtag_rd_done  = 1'b0;
    cpu_issue     = 1'b0;
    jtag_issue    = 1'b0;
    overrun_d     = overrun_q | (req_evt & (state_q != StJtagIdle));

    unique case (state_q)
      StCpu: begin
        cpu_issue = cpu_req & ~cpu_pend_q;
        if (en_s) begin
          state_d    = StDrain;
          cpu_halt_d = 1'b1;
        end
      end
      StDrain: state_d = StJtagIdle;
      StJtagIdle: begin
        if (req_evt) begin
          state_d      = StJtagAccess;
          jtag_capture = 1'b1;
        end else if (!en_s) begin
          state_d       = StRelease;
          cnt_d         = CntLoad;
          cpu_rst_req_d = 1'b1;
        end
      end
      StJtagAccess: begin
        jtag_issue = 1'b1;
        if (jtag_we_q) begin
          jtag_ack_d = 1'b1;
          state_d    = StJtagIdle;
        end else begin
          state_d = StJtagRead;
        end
      end
      StJtagRead: begin
        jtag_ack_d   = 1'b1;
        jtag_rd_done = 1'b1;
        state_d      = StJtagIdle;
      end
      StRelease: begin
        if (cnt_q == '0) begin
          state_d       = StCpu;
          cpu_halt_d    = 1'b0;
          cpu_rst_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StCpu;
    endcase

    if (cpu_issue) begin
      cpu_pend_d    = 1'b1;
      cpu_pend_we_d = cpu_we;
    end
  end

  assign cpu_rd_done = cpu_pend_q & ~cpu_pend_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StCpu;
      en_sync_q     <= '0;
      req_sync_q    <= '0;
      req_s_q       <= 1'b0;
      cpu_pend_q    <= 1'b0;
      cpu_pend_we_q <= 1'b0;
      cpu_halt_q    <= 1'b0;
      cpu_rst_req_q <= 1'b0;
      cpu_rdata_q   <= '0;
      cnt_q         <= '0;
      jtag_we_q     <= 1'b0;
      jtag_addr_q   <= '0;
      jtag_wdata_q  <= '0;
      jtag_rdata_q  <= '0;
      jtag_ack_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_sync_q     <= {en_sync_q[SYNC_STAGES-2:0], jtag_en_async};
      req_sync_q    <= {req_sync_q[SYNC_STAGES-2:0], jtag_req_async};
      req_s_q       <= req_s;
      cpu_pend_q    <= cpu_pend_d;
      cpu_pend_we_q <= cpu_pend_we_d;
      cpu_halt_q    <= cpu_halt_d;
      cpu_rst_req_q <= cpu_rst_req_d;
      cnt_q         <= cnt_d;
      jtag_ack_q    <= jtag_ack_d;
      overrun_q     <= overrun_d;
      if (cpu_rd_done) cpu_rdata_q <= mem_rdata;
      if (jtag_rd_done) jtag_rdata_q <= mem_rdata;
      if (jtag_capture) begin
        jtag_we_q    <= jtag_we;
        jtag_addr_q  <= jtag_addr;
        jtag_wdata_q <= jtag_wdata;
      end
    end
  end

  assign mem_en    = cpu_issue | jtag_issue;
  assign mem_we    = jtag_issue ? jtag_we_q : cpu_we;
  assign mem_addr  = jtag_issue ? jtag_addr_q : cpu_addr;
  assign mem_wdata = jtag_issue ? jtag_wdata_q : cpu_wdata;

  // Read data is forwarded in the ready cycle and held afterwards.
  assign cpu_rdata    = cpu_rd_done ? mem_rdata : cpu_rdata_q;
  assign cpu_ready    = cpu_pend_q;
  assign cpu_halt     = cpu_halt_q;
  assign cpu_rst_req  = cpu_rst_req_q;
  assign jtag_rdata   = jtag_rdata_q;
  assign jtag_ack     = jtag_ack_q;
  assign jtag_overrun = overrun_q;

endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// Scoreboard bench for jtag_mem_arbiter: directed stimulus pushes expectations,
// a negedge monitor pops and compares on cpu_ready / jtag_ack.
module tb_jtag_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          jtag_en_async, jtag_req_async, jtag_we;
  logic [AW-1:0] jtag_addr;
  logic [DW-1:0] jtag_wdata, jtag_rdata;
  logic          jtag_ack, jtag_overrun;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_halt, cpu_rst_req;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  jtag_mem_arbiter #(
    .MEM_ADDR_WIDTH(AW),
    .MEM_DATA_WIDTH(DW),
    .RST_CYCLES    (8),
    .SYNC_STAGES   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .jtag_en_async (jtag_en_async),
    .jtag_req_async(jtag_req_async),
    .jtag_we       (jtag_we),
    .jtag_addr     (jtag_addr),
    .jtag_wdata    (jtag_wdata),
    .jtag_rdata    (jtag_rdata),
    .jtag_ack      (jtag_ack),
    .jtag_overrun  (jtag_overrun),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ready     (cpu_ready),
    .cpu_halt      (cpu_halt),
    .cpu_rst_req   (cpu_rst_req),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Synchronous SRAM model: read data valid one clock after the strobe.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t jtag_q[$];
  exp_t mon_e;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   mem_en_cnt = 0;
  int   last_mem_cyc = 0;
  int   cpu_rdy_cnt = 0;
  int   jtag_ack_cnt = 0;
  logic prev_mem_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mem_en = 1'b0;
    end else begin
      if (mem_en) begin
        check("mem_en back-to-back", 32'(prev_mem_en), 32'd0);
        mem_en_cnt++;
        last_mem_cyc = cyc;
      end
      prev_mem_en = mem_en;
      if (cpu_ready) begin
        cpu_rdy_cnt++;
        check("cpu_ready during cpu_rst_req", 32'(cpu_rst_req), 32'd0);
        if (cpu_q.size() == 0) begin
          check("cpu_ready unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = cpu_q.pop_front();
          if (mon_e.rd) check("cpu_rdata", cpu_rdata, mon_e.data);
        end
      end
      if (jtag_ack) begin
        jtag_ack_cnt++;
        if (jtag_q.size() == 0) begin
          check("jtag_ack unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = jtag_q.pop_front();
          if (mon_e.rd) check("jtag_rdata", jtag_rdata, mon_e.data);
          check("jtag_ack latency after strobe", 32'(cyc - last_mem_cyc),
                mon_e.rd ? 32'd2 : 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_jtag, input logic rd, input logic [DW-1:0] d);
    exp_t e;
    e.rd   = rd;
    e.data = d;
    if (is_jtag) jtag_q.push_back(e);
    else         cpu_q.push_back(e);
  endtask

  task automatic wait_cnt(input bit is_jtag, input int base, input int lim, input string name);
    int n = 0;
    while (((is_jtag ? jtag_ack_cnt : cpu_rdy_cnt) == base) && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'((is_jtag ? jtag_ack_cnt : cpu_rdy_cnt) - base), 32'd1);
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!cpu_halt && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(cpu_halt), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " jtag_rdata"},   jtag_rdata, 32'd0);
    check({tag, " jtag_ack"},     32'(jtag_ack), 32'd0);
    check({tag, " jtag_overrun"}, 32'(jtag_overrun), 32'd0);
    check({tag, " cpu_ready"},    32'(cpu_ready), 32'd0);
    check({tag, " cpu_rdata"},    cpu_rdata, 32'd0);
    check({tag, " cpu_halt"},     32'(cpu_halt), 32'd0);
    check({tag, " cpu_rst_req"},  32'(cpu_rst_req), 32'd0);
    check({tag, " mem_en"},       32'(mem_en), 32'd0);
  endtask

  task automatic jtag_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp);
    int b;
    jtag_we    = we;
    jtag_addr  = a;
    jtag_wdata = d;
    tick(8);  // quasi-static fields settle >= 2 tck before the pulse
    b = jtag_ack_cnt;
    push_exp(1'b1, ~we, exp);
    jtag_req_async = 1'b1;
    tick(4);
    jtag_req_async = 1'b0;
    wait_cnt(1'b1, b, 30, we ? "jtag write ack" : "jtag read ack");
  endtask

  initial begin
    int b, b_hold, c0, c1, w_cyc, n, len;
    logic halt_ok;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    jtag_en_async = 0; jtag_req_async = 0; jtag_we = 0; jtag_addr = '0; jtag_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;

    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // CPU-only write then read, request held across both
    push_exp(1'b0, 1'b0, '0);
    b = cpu_rdy_cnt;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF;
    wait_cnt(1'b0, b, 10, "cpu write ready");
    w_cyc = last_mem_cyc;
    tick(1);
    cpu_we = 0;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    b = cpu_rdy_cnt;
    wait_cnt(1'b0, b, 10, "cpu read ready");
    check("cpu mem_en spacing", 32'(last_mem_cyc - w_cyc), 32'd2);
    tick(1);
    cpu_req = 0;

    // JTAG entry with a CPU access in flight
    tick(2);
    push_exp(1'b0, 1'b0, '0);
    b = cpu_rdy_cnt;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'hA5A5A5A5;
    jtag_en_async = 1;
    wait_cnt(1'b0, b, 10, "in-flight cpu ready");
    tick(1);
    cpu_req = 0;
    wait_halt("cpu_halt on entry");
    tick(1);
    b_hold = cpu_rdy_cnt;
    push_exp(1'b0, 1'b1, 32'h12345678);
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
    c0 = mem_en_cnt;
    tick(6);
    check("no cpu mem_en while halted", 32'(mem_en_cnt - c0), 32'd0);

    // JTAG write then read at the top address, tck = clk/4
    jtag_op(1'b1, 10'h3FF, 32'h12345678, '0);
    tick(4);
    jtag_op(1'b0, 10'h3FF, '0, 32'h12345678);
    check("overrun after clean jtag ops", 32'(jtag_overrun), 32'd0);
    check("no cpu_ready while halted", 32'(cpu_rdy_cnt - b_hold), 32'd0);

    // Release: fixed-length CPU reset, then the held read is served
    tick(1);
    jtag_en_async = 0;
    n = 0;
    while (!cpu_rst_req && n < 20) begin
      @(negedge clk); #1; n++;
    end
    len = 0;
    halt_ok = 1'b1;
    while (cpu_rst_req && len < 40) begin
      if (!cpu_halt) halt_ok = 1'b0;
      len++;
      @(negedge clk); #1;
    end
    check("cpu_rst_req length", 32'(len), 32'd8);
    check("cpu_halt high with cpu_rst_req", 32'(halt_ok), 32'd1);
    check("cpu_halt falls with cpu_rst_req", 32'(cpu_halt), 32'd0);
    wait_cnt(1'b0, b_hold, 20, "held cpu read ready");
    tick(1);
    cpu_req = 0;

    // Request with jtag_en low is dropped and sticks
    tick(2);
    c0 = mem_en_cnt;
    jtag_req_async = 1;
    tick(4);
    jtag_req_async = 0;
    tick(10);
    check("no mem_en for dropped req", 32'(mem_en_cnt - c0), 32'd0);
    check("overrun set by dropped req", 32'(jtag_overrun), 32'd1);
    tick(20);
    check("overrun sticky", 32'(jtag_overrun), 32'd1);

    // Reset clears overrun; then a second pulse lands during the read access
    rst_n = 0;
    tick(2);
    check("overrun cleared by reset", 32'(jtag_overrun), 32'd0);
    rst_n = 1;
    tick(2);
    jtag_en_async = 1;
    wait_halt("cpu_halt on second entry");
    tick(4);
    jtag_we = 0; jtag_addr = 10'h3FF;
    tick(8);
    push_exp(1'b1, 1'b1, 32'h12345678);
    c0 = mem_en_cnt;
    c1 = jtag_ack_cnt;
    jtag_req_async = 1; tick(1);
    jtag_req_async = 0; tick(1);
    jtag_req_async = 1; tick(1);
    jtag_req_async = 0;
    tick(12);
    check("one strobe for double pulse", 32'(mem_en_cnt - c0), 32'd1);
    check("one ack for double pulse", 32'(jtag_ack_cnt - c1), 32'd1);
    check("overrun set by busy drop", 32'(jtag_overrun), 32'd1);

    // Reset in the middle of a JTAG read
    jtag_addr = 10'h005;
    tick(8);
    push_exp(1'b1, 1'b1, 32'hDEADBEEF);
    jtag_req_async = 1;
    n = 0;
    while (!mem_en && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("jtag read strobe seen", 32'(mem_en), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 0;
    jtag_req_async = 0;
    jtag_en_async = 0;
    cpu_q.delete();
    jtag_q.delete();
    #1;
    check_reset_outputs("mid-read reset");
    tick(2);
    rst_n = 1;
    tick(3);
    push_exp(1'b0, 1'b1, 32'h12345678);
    b = cpu_rdy_cnt;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
    wait_cnt(1'b0, b, 10, "cpu read after reset");
    tick(1);
    cpu_req = 0;
    tick(3);
    check("cpu queue drained", 32'(cpu_q.size()), 32'd0);
    check("jtag queue drained", 32'(jtag_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
